mem_map_router: RTL and testbench

//  Parametrised memory-map router between the CPU load/store port and its targets: data cache (RAM),

---
 rtl/mem_map_router_if.sv | 21 ++
 rtl/mem_map_router.sv | 171 +++++++++++++++++
 tb/tb_mem_map_router.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_map_router_if.sv
// CPU load/store bus between the execute stage and the memory-map router.
// The master drives a request and holds it while stall=1; the slave answers with stall/read_data/fault.
interface mem_map_router_if;
    logic        mem_en;
    logic [1:0]  store_size;
    logic [31:0] mem_addr;
    logic [31:0] write_data;
    logic        stall;
    logic [31:0] read_data;
    logic        fault;

    modport master (
        output mem_en, store_size, mem_addr, write_data,
        input  stall, read_data, fault
    );

    modport slave (
        input  mem_en, store_size, mem_addr, write_data,
        output stall, read_data, fault
    );
endinterface

// File: rtl/mem_map_router.sv
// Memory-map router: decodes CPU accesses to dcache RAM, video memory or the keyboard register,
// runs the dcache request/ready handshake with a timeout, and flags bad accesses.
module mem_map_router #(
    parameter int          RAM_AW   = 20,
    parameter logic [31:0] VID_BASE = 32'hF0000000,
    parameter int          VID_AW   = 11,
    parameter logic [31:0] KEY_ADDR = 32'hFFFFFFFF,
    parameter int          TIMEOUT  = 15
) (
    input  logic              CLK_CPU,
    input  logic              RST,
    mem_map_router_if.slave   cpu,
    output logic              dcache_req,
    output logic              dcache_we,
    output logic [3:0]        dcache_be,
    output logic [RAM_AW-1:0] dcache_addr,
    output logic [31:0]       dcache_wdata,
    input  logic [31:0]       dcache_rdata,
    input  logic              dcache_ready,
    output logic              video_we,
    output logic [3:0]        video_be,
    output logic [VID_AW-1:0] video_addr,
    output logic [31:0]       video_wdata,
    input  logic [7:0]        pressed_key,
    output logic              clean_key_buffer,
    output logic [1:0]        dbg_state_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              to_q, to_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [RAM_AW-1:2] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        is_key, is_ram, is_vid, is_read, misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    assign is_key  = (cpu.mem_addr == KEY_ADDR);
    assign is_ram  = (cpu.mem_addr[31:RAM_AW] == '0);
    assign is_vid  = (cpu.mem_addr[31:VID_AW] == VID_BASE[31:VID_AW]);
    assign is_read = (cpu.store_size == 2'b11);
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        misaligned = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = cpu.write_data;
        case (cpu.store_size)
            2'b00: begin
                be_c    = 4'b0001 << cpu.mem_addr[1:0];
                wdata_c = {4{cpu.write_data[7:0]}};
            end
            2'b01: begin
                misaligned = cpu.mem_addr[0];
                be_c       = cpu.mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{cpu.write_data[15:0]}};
            end
            default: misaligned = (cpu.mem_addr[1:0] != 2'b00);
        endcase
    end

    assign video_be     = be_c;
    assign video_addr   = {cpu.mem_addr[VID_AW-1:2], 2'b00};
    assign video_wdata  = wdata_c;
    assign dcache_we    = we_q;
    assign dcache_be    = be_q;
    assign dcache_addr  = {addr_q, 2'b00};
    assign dcache_wdata = wdata_q;
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        to_d             = to_q;
        rdata_d          = rdata_q;
        addr_d           = addr_q;
        we_d             = we_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        cpu.stall        = 1'b0;
        cpu.fault        = 1'b0;
        cpu.read_data    = rdata_q;
        dcache_req       = 1'b0;
        video_we         = 1'b0;
        clean_key_buffer = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu.mem_en) begin
                    if (is_key) begin
                        if (is_read) begin
                            cpu.read_data    = {24'b0, pressed_key};
                            clean_key_buffer = 1'b1;
                        end else begin
                            cpu.fault     = 1'b1;
                            cpu.read_data = '0;
                        end
                    end else if (is_ram && !misaligned) begin
                        cpu.stall = 1'b1;
                        state_d   = S_WAIT;
                        cnt_d     = '0;
                        to_d      = 1'b0;
                        addr_d    = cpu.mem_addr[RAM_AW-1:2];
                        we_d      = !is_read;
                        be_d      = be_c;
                        wdata_d   = wdata_c;
                    end else if (is_vid && !is_read && !misaligned) begin
                        video_we      = 1'b1;
                        cpu.read_data = '0;
                    end else begin
                        cpu.fault     = 1'b1;
                        cpu.read_data = '0;
                    end
                end
            end
            S_WAIT: begin
                // cnt_inc counts WAIT cycles including this one, so req is held at most TIMEOUT cycles.
                cpu.stall  = 1'b1;
                dcache_req = 1'b1;
                cnt_d      = cnt_inc;
                if (dcache_ready) begin
                    state_d = S_DONE;
                    rdata_d = we_q ? 32'b0 : dcache_rdata;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                    rdata_d = '0;
                end
            end
            S_DONE: begin
                cpu.fault = to_q;
                state_d   = S_IDLE;
                cnt_d     = '0;
                to_d      = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_CPU) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_map_router.sv
// Randomized bench for mem_map_router against a behavioural address-map model.
module tb_mem_map_router;
    localparam int          RAM_AW   = 20;
    localparam logic [31:0] VID_BASE = 32'hF0000000;
    localparam int          VID_AW   = 11;
    localparam logic [31:0] KEY_ADDR = 32'hFFFFFFFF;
    localparam int          TIMEOUT  = 15;

    localparam int K_RAM = 0, K_VID = 1, K_KEY = 2, K_FAULT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_map_router_if cpu ();
    logic              dcache_req, dcache_we, dcache_ready;
    logic [3:0]        dcache_be;
    logic [RAM_AW-1:0] dcache_addr;
    logic [31:0]       dcache_wdata, dcache_rdata;
    logic              video_we;
    logic [3:0]        video_be;
    logic [VID_AW-1:0] video_addr;
    logic [31:0]       video_wdata;
    logic [7:0]        pressed_key;
    logic              clean_key_buffer;
    logic [1:0]        dbg_state;

    mem_map_router #(
        .RAM_AW(RAM_AW), .VID_BASE(VID_BASE), .VID_AW(VID_AW),
        .KEY_ADDR(KEY_ADDR), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_CPU(clk), .RST(rst), .cpu(cpu.slave),
        .dcache_req(dcache_req), .dcache_we(dcache_we), .dcache_be(dcache_be),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_ready(dcache_ready),
        .video_we(video_we), .video_be(video_be), .video_addr(video_addr),
        .video_wdata(video_wdata), .pressed_key(pressed_key),
        .clean_key_buffer(clean_key_buffer), .dbg_state_o(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: address map and lane rules in plain arithmetic.
    function automatic int classify(input logic [1:0] sz, input logic [31:0] a);
        longint ua = longint'(a);
        bit rd  = (sz == 2'd3);
        bit mis = (sz >= 2'd2) ? (ua % 4 != 0) : (sz == 2'd1) ? (ua % 2 != 0) : 1'b0;
        if (a == KEY_ADDR) return rd ? K_KEY : K_FAULT;
        if (ua < (longint'(1) << RAM_AW)) return mis ? K_FAULT : K_RAM;
        if (ua >= longint'(VID_BASE) && ua < longint'(VID_BASE) + (longint'(1) << VID_AW))
            return (rd || mis) ? K_FAULT : K_VID;
        return K_FAULT;
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        if (sz == 2'd0) return 32'(1 << off);
        if (sz == 2'd1) return (off >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd % 256) * 32'h01010101;
        if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        cpu.mem_en     = 1'b1;
        cpu.store_size = sz;
        cpu.mem_addr   = a;
        cpu.write_data = wd;
    endtask

    task automatic one_cycle_access(input logic [1:0] sz, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [7:0] key);
        int k = classify(sz, a);
        drive(sz, a, wd);
        pressed_key = key;
        exp_q.push_back((k == K_KEY) ? {24'b0, key} : 32'b0);
        #3;
        check("stall_1cyc", 32'(cpu.stall), 32'd0);
        check("fault_1cyc", 32'(cpu.fault), 32'(k == K_FAULT));
        check("video_we", 32'(video_we), 32'(k == K_VID));
        check("clean_key", 32'(clean_key_buffer), 32'(k == K_KEY));
        check("dcache_req_1cyc", 32'(dcache_req), 32'd0);
        check("read_data_1cyc", cpu.read_data, exp_q.pop_front());
        if (k == K_VID) begin
            check("video_be", 32'(video_be), model_be(sz, a));
            check("video_addr", 32'(video_addr), ((a - VID_BASE) / 4) * 4);
            check("video_wdata", video_wdata, model_wdata(sz, wd));
        end
        tick();
        cpu.mem_en = 1'b0;
        #3;
        check("fault_pulse_end", 32'(cpu.fault), 32'd0);
        tick();
    endtask

    // dly = WAIT cycle (1-based) in which dcache_ready pulses; beyond TIMEOUT means never.
    task automatic ram_access(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                              input int dly, input logic [31:0] rd);
        int  reqs = 0;
        bit  to   = !(dly >= 1 && dly <= TIMEOUT);
        drive(sz, a, wd);
        dcache_ready = 1'b0;
        exp_q.push_back((sz == 2'd3 && !to) ? rd : 32'b0);
        #3;
        check("stall_idle", 32'(cpu.stall), 32'd1);
        check("req_idle", 32'(dcache_req), 32'd0);
        check("fault_idle", 32'(cpu.fault), 32'd0);
        tick();
        for (int c = 1; c <= TIMEOUT; c++) begin
            dcache_ready = (c == dly);
            dcache_rdata = (c == dly) ? rd : $urandom;
            #3;
            if (c == 1) begin
                check("dc_addr", 32'(dcache_addr), (a / 4) * 4);
                check("dc_we", 32'(dcache_we), 32'(sz != 2'd3));
                check("dc_be", 32'(dcache_be), model_be(sz, a));
                check("dc_wdata", dcache_wdata, model_wdata(sz, wd));
                check("stall_wait", 32'(cpu.stall), 32'd1);
            end
            if (dcache_req === 1'b1) reqs++;
            tick();
            if (c == dly) break;
        end
        dcache_ready = 1'b0;
        #3;
        check("stall_done", 32'(cpu.stall), 32'd0);
        check("fault_done", 32'(cpu.fault), 32'(to));
        check("read_data_done", cpu.read_data, exp_q.pop_front());
        check("req_done", 32'(dcache_req), 32'd0);
        check("req_cycles", 32'(reqs), to ? 32'(TIMEOUT) : 32'(dly));
        tick();
        cpu.mem_en = 1'b0;
        #3;
        check("post_done_stall", 32'(cpu.stall), 32'd0);
        check("post_done_fault", 32'(cpu.fault), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        cpu.mem_en     = 1'b0;
        cpu.store_size = 2'b11;
        cpu.mem_addr   = '0;
        cpu.write_data = '0;
        dcache_ready   = 1'b0;
        dcache_rdata   = '0;
        pressed_key    = '0;
        tick();
        tick();
        rst = 1'b0;
        #3;
        check("rst_stall", 32'(cpu.stall), 32'd0);
        check("rst_fault", 32'(cpu.fault), 32'd0);
        check("rst_read_data", cpu.read_data, 32'd0);
        check("rst_req", 32'(dcache_req), 32'd0);
        check("rst_video_we", 32'(video_we), 32'd0);
        check("rst_clean", 32'(clean_key_buffer), 32'd0);
        tick();

        ram_access(2'b11, 32'h00000100, 32'h0, 3, 32'hDEADBEEF);
        one_cycle_access(2'b00, 32'hF0000006, 32'h000000A5, 8'h00);
        one_cycle_access(2'b11, 32'hFFFFFFFF, 32'h0, 8'h41);
        one_cycle_access(2'b01, 32'h00000003, 32'h1234, 8'h00);
        one_cycle_access(2'b11, 32'h80000000, 32'h0, 8'h00);
        one_cycle_access(2'b11, 32'hF0000010, 32'h0, 8'h00);
        one_cycle_access(2'b10, 32'hFFFFFFFF, 32'h55, 8'h00);
        one_cycle_access(2'b01, 32'hF00007FE, 32'hBEEF, 8'h00);
        ram_access(2'b10, 32'h00000040, 32'h12345678, TIMEOUT + 5, 32'h0);
        ram_access(2'b11, 32'h00000200, 32'h0, TIMEOUT, 32'hCAFEF00D);
        ram_access(2'b00, 32'h000FFFFF, 32'h3C, 1, 32'h0);
        ram_access(2'b01, 32'h00000012, 32'hABCD, 2, 32'h0);

        // Reset in the middle of a dcache wait.
        drive(2'b11, 32'h00000300, 32'h0);
        dcache_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        cpu.mem_en = 1'b0;
        #3;
        check("rstwait_req", 32'(dcache_req), 32'd0);
        check("rstwait_stall", 32'(cpu.stall), 32'd0);
        check("rstwait_fault", 32'(cpu.fault), 32'd0);
        check("rstwait_read_data", cpu.read_data, 32'd0);
        tick();
        ram_access(2'b11, 32'h00000300, 32'h0, 2, 32'h600DF00D);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, (1 << RAM_AW) - 1));
                1:       a = VID_BASE + 32'($urandom_range(0, (1 << VID_AW) - 1));
                2:       a = KEY_ADDR;
                default: a = 32'h40000000 | $urandom;
            endcase
            if (classify(sz, a) == K_RAM)
                ram_access(sz, a, $urandom, $urandom_range(1, TIMEOUT + 3), $urandom);
            else
                one_cycle_access(sz, a, $urandom, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
